// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-access stage: funct3 access-size codes,
// the request FSM state type and the writeback-mux select encodings.
package lsu_pkg;

    // funct3 encodings for loads/stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // ResultSrc encodings for the writeback mux
    localparam logic [1:0] RS_ALU = 2'b00;
    localparam logic [1:0] RS_MEM = 2'b01;
    localparam logic [1:0] RS_PC4 = 2'b10;

    // Data-memory request FSM
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational byte-lane logic for the memory stage.
// Ports:
//   funct3       access size / sign
//   addr_lo      effective address bits [1:0]
//   mem_read     load in flight
//   mem_write    store in flight
//   store_data   rs2 value
//   load_raw     raw word from memory
//   be           byte enables (all lanes for loads)
//   store_lanes  store data replicated into its byte lanes
//   load_ext     selected and sign/zero-extended load data
//   fault        illegal funct3 or misaligned access
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [3:0]  be,
    output logic [31:0] store_lanes,
    output logic [31:0] load_ext,
    output logic        fault
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Fault detection: illegal size codes and misalignment
    always_comb begin
        fault = 1'b0;
        if (mem_read) begin
            case (funct3)
                F3_B, F3_BU: fault = 1'b0;
                F3_H, F3_HU: fault = addr_lo[0];
                F3_W:        fault = (addr_lo != 2'b00);
                default:     fault = 1'b1;
            endcase
        end else if (mem_write) begin
            case (funct3)
                F3_B:    fault = 1'b0;
                F3_H:    fault = addr_lo[0];
                F3_W:    fault = (addr_lo != 2'b00);
                default: fault = 1'b1;
            endcase
        end else begin
            fault = 1'b0;
        end
    end

    // Store lane placement; loads always enable the full word
    always_comb begin
        be          = 4'b1111;
        store_lanes = store_data;
        if (mem_write && !mem_read) begin
            case (funct3)
                F3_B: begin
                    be          = 4'b0001 << addr_lo;
                    store_lanes = {4{store_data[7:0]}};
                end
                F3_H: begin
                    be          = 4'b0011 << addr_lo;
                    store_lanes = {2{store_data[15:0]}};
                end
                default: begin
                    be          = 4'b1111;
                    store_lanes = store_data;
                end
            endcase
        end else begin
            be          = 4'b1111;
            store_lanes = store_data;
        end
    end

    // Load lane selection and extension
    always_comb begin
        case (addr_lo)
            2'd0:    byte_s = load_raw[7:0];
            2'd1:    byte_s = load_raw[15:8];
            2'd2:    byte_s = load_raw[23:16];
            2'd3:    byte_s = load_raw[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = addr_lo[1] ? load_raw[31:16] : load_raw[15:0];
        case (funct3)
            F3_B:    load_ext = {{24{byte_s[7]}}, byte_s};
            F3_H:    load_ext = {{16{half_s[15]}}, half_s};
            F3_W:    load_ext = load_raw;
            F3_BU:   load_ext = {24'h000000, byte_s};
            F3_HU:   load_ext = {16'h0000, half_s};
            default: load_ext = 32'h00000000;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-access stage of the RV32I pipeline: drives the req/ack data-memory
// port, stalls while an access is outstanding, watches for bus timeouts and
// holds the MEM/WB pipeline register.
// Ports:
//   CLK, RST_N                       clock, async active-low reset
//   *M inputs                        EX/MEM register fields
//   DMemReq/We/Addr/WData/Be         data-memory request side
//   DMemAck/DMemRData                data-memory response side
//   StallM                           freezes F/D/E/M registers
//   *W outputs                       MEM/WB register fields, ExcW exception
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 5,
    parameter int FUNCT3_WIDTH   = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     RegWriteM,
    input  logic [1:0]               ResultSrcM,
    input  logic                     MemWriteM,
    input  logic                     MemReadM,
    input  logic [DATA_WIDTH-1:0]    ALUResultM,
    input  logic [DATA_WIDTH-1:0]    WriteDataM,
    input  logic [ADDRESS_WIDTH-1:0] RdM,
    input  logic [DATA_WIDTH-1:0]    PCPlus4M,
    input  logic [FUNCT3_WIDTH-1:0]  funct3M,
    output logic                     DMemReq,
    output logic                     DMemWe,
    output logic [DATA_WIDTH-1:0]    DMemAddr,
    output logic [DATA_WIDTH-1:0]    DMemWData,
    output logic [3:0]               DMemBe,
    input  logic                     DMemAck,
    input  logic [DATA_WIDTH-1:0]    DMemRData,
    output logic                     StallM,
    output logic                     RegWriteW,
    output logic [1:0]               ResultSrcW,
    output logic [DATA_WIDTH-1:0]    ALUResultW,
    output logic [DATA_WIDTH-1:0]    ReadDataW,
    output logic [ADDRESS_WIDTH-1:0] RdW,
    output logic [DATA_WIDTH-1:0]    PCPlus4W,
    output logic                     ExcW
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e            state_r;
    lsu_state_e            state_nx_s;
    logic [CW-1:0]         cnt_r;
    logic [CW-1:0]         cnt_nx_s;
    logic                  memop_s;
    logic                  fault_s;
    logic                  req_s;
    logic                  timeout_now_s;
    logic                  stall_s;
    logic                  exc_s;
    logic [DATA_WIDTH-1:0] load_ext_s;

    lsu_align u_align (
        .funct3      (funct3M),
        .addr_lo     (ALUResultM[1:0]),
        .mem_read    (MemReadM),
        .mem_write   (MemWriteM),
        .store_data  (WriteDataM),
        .load_raw    (DMemRData),
        .be          (DMemBe),
        .store_lanes (DMemWData),
        .load_ext    (load_ext_s),
        .fault       (fault_s)
    );

    assign memop_s  = MemReadM | MemWriteM;
    assign DMemWe   = MemWriteM;
    assign DMemAddr = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
    assign DMemReq  = req_s;
    assign StallM   = stall_s;
    assign exc_s    = fault_s | timeout_now_s;

    // Request is gated by reset so it drops asynchronously mid-WAIT
    always_comb begin
        if (!RST_N) begin
            req_s = 1'b0;
        end else if (state_r == WAIT) begin
            req_s = 1'b1;
        end else begin
            req_s = memop_s & ~fault_s;
        end
    end

    // cnt_r counts cycles the request has been outstanding (IDLE cycle is 0)
    always_comb begin
        timeout_now_s = req_s & ~DMemAck & (cnt_r == CW'(TIMEOUT_CYCLES - 1));
        stall_s       = req_s & ~DMemAck & ~timeout_now_s;
    end

    // FSM next-state and watchdog counter update
    always_comb begin
        state_nx_s = IDLE;
        cnt_nx_s   = {CW{1'b0}};
        case (state_r)
            IDLE: begin
                if (stall_s) begin
                    state_nx_s = WAIT;
                    cnt_nx_s   = CW'(1);
                end else begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = {CW{1'b0}};
                end
            end
            WAIT: begin
                if (stall_s) begin
                    state_nx_s = WAIT;
                    cnt_nx_s   = cnt_r + CW'(1);
                end else begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = {CW{1'b0}};
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = {CW{1'b0}};
            end
        endcase
    end

    // FSM state and counter registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // MEM/WB register; a stall loads a bubble and leaves data fields held
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= {DATA_WIDTH{1'b0}};
            ReadDataW  <= {DATA_WIDTH{1'b0}};
            RdW        <= {ADDRESS_WIDTH{1'b0}};
            PCPlus4W   <= {DATA_WIDTH{1'b0}};
            ExcW       <= 1'b0;
        end else if (stall_s) begin
            RegWriteW  <= 1'b0;
            ExcW       <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM & ~exc_s;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= (MemReadM && DMemAck && !fault_s) ? load_ext_s : {DATA_WIDTH{1'b0}};
            RdW        <= RdM;
            PCPlus4W   <= PCPlus4M;
            ExcW       <= exc_s;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic        MemReadM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M;
    logic [2:0]  funct3M;
    logic        DMemReq;
    logic        DMemWe;
    logic [31:0] DMemAddr;
    logic [31:0] DMemWData;
    logic [3:0]  DMemBe;
    logic        DMemAck;
    logic [31:0] DMemRData;
    logic        StallM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [4:0]  RdW;
    logic [31:0] PCPlus4W;
    logic        ExcW;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        regwrite;
        logic        exc;
        logic [31:0] readdata;
        logic [4:0]  rd;
        logic [31:0] alures;
        logic [31:0] pc4;
        logic [1:0]  rs;
        int          stalls;
    } wb_exp_t;

    wb_exp_t sb_q[$];

    always #5 CLK = ~CLK;

    mem_stage_lsu #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(5), .FUNCT3_WIDTH(3), .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .MemReadM(MemReadM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RdM(RdM), .PCPlus4M(PCPlus4M), .funct3M(funct3M),
        .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr),
        .DMemWData(DMemWData), .DMemBe(DMemBe), .DMemAck(DMemAck),
        .DMemRData(DMemRData), .StallM(StallM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W), .ExcW(ExcW)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One instruction through M: drive, check request side, serve ack after
    // 'delay' stall cycles (never if delay is large), then compare MEM/WB.
    task automatic run_op(input string name, input logic rw, input logic [1:0] rs,
                          input logic mr, input logic mw, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input logic [31:0] pc4,
                          input int delay, input logic [31:0] rdata,
                          input logic exp_req, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input int exp_stalls,
                          input logic exp_exc, input logic exp_rw,
                          input logic [31:0] exp_rdata);
        wb_exp_t e;
        wb_exp_t got_e;
        int stalls;
        @(negedge CLK);
        RegWriteM = rw; ResultSrcM = rs; MemReadM = mr; MemWriteM = mw;
        funct3M = f3; ALUResultM = addr; WriteDataM = wd; RdM = rd; PCPlus4M = pc4;
        DMemRData = rdata;
        DMemAck = (delay == 0);
        e.regwrite = exp_rw; e.exc = exp_exc; e.readdata = exp_rdata; e.rd = rd;
        e.alures = addr; e.pc4 = pc4; e.rs = rs; e.stalls = exp_stalls;
        sb_q.push_back(e);
        #1;
        chk({name, ".req"}, {31'd0, DMemReq}, {31'd0, exp_req});
        if (exp_req) begin
            chk({name, ".we"},   {31'd0, DMemWe}, {31'd0, mw});
            chk({name, ".addr"}, DMemAddr, {addr[31:2], 2'b00});
            chk({name, ".be"},   {28'd0, DMemBe}, {28'd0, exp_be});
            if (mw) chk({name, ".wdata"}, DMemWData, exp_wd);
        end
        stalls = 0;
        while (StallM && stalls < 40) begin
            @(posedge CLK);
            #1;
            chk({name, ".bubble_rw"},  {31'd0, RegWriteW}, 32'd0);
            chk({name, ".bubble_exc"}, {31'd0, ExcW}, 32'd0);
            stalls++;
            @(negedge CLK);
            DMemAck = (stalls == delay);
            #1;
        end
        if (stalls >= 40) begin
            n_cmp++; n_err++;
            $error("FAIL %s.stall_bound: observed stuck stall expected release", name);
        end
        @(posedge CLK);
        #1;
        got_e = sb_q.pop_front();
        chk({name, ".stalls"},   stalls, got_e.stalls);
        chk({name, ".RegWriteW"}, {31'd0, RegWriteW}, {31'd0, got_e.regwrite});
        chk({name, ".ExcW"},      {31'd0, ExcW}, {31'd0, got_e.exc});
        chk({name, ".ReadDataW"}, ReadDataW, got_e.readdata);
        chk({name, ".RdW"},       {27'd0, RdW}, {27'd0, got_e.rd});
        chk({name, ".ALUResultW"}, ALUResultW, got_e.alures);
        chk({name, ".PCPlus4W"},  PCPlus4W, got_e.pc4);
        chk({name, ".ResultSrcW"}, {30'd0, ResultSrcW}, {30'd0, got_e.rs});
        DMemAck = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0;
        RegWriteM = 1'b0; ResultSrcM = 2'b00; MemReadM = 1'b0; MemWriteM = 1'b0;
        funct3M = 3'b000; ALUResultM = 32'h0; WriteDataM = 32'h0; RdM = 5'd0;
        PCPlus4M = 32'h0; DMemAck = 1'b0; DMemRData = 32'h0;
        #12;
        chk("reset.req",   {31'd0, DMemReq}, 32'd0);
        chk("reset.stall", {31'd0, StallM}, 32'd0);
        chk("reset.rw",    {31'd0, RegWriteW}, 32'd0);
        chk("reset.exc",   {31'd0, ExcW}, 32'd0);
        chk("reset.pc4",   PCPlus4W, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        //     name    rw    rs     mr    mw    f3      addr          wdata         rd     pc4           dly rdata         req   be       wd            st ex    rwW   rdataW
        run_op("sw",   1'b0, 2'b00, 1'b0, 1'b1, 3'b010, 32'h00000100, 32'hDEADBEEF, 5'd0,  32'h00001004, 0,  32'h0,        1'b1, 4'b1111, 32'hDEADBEEF, 0, 1'b0, 1'b0, 32'h0);
        run_op("lb",   1'b1, 2'b01, 1'b1, 1'b0, 3'b000, 32'h00000103, 32'h0,        5'd5,  32'h00001008, 3,  32'h80FFFF7F, 1'b1, 4'b1111, 32'h0,        3, 1'b0, 1'b1, 32'hFFFFFF80);
        run_op("lbu",  1'b1, 2'b01, 1'b1, 1'b0, 3'b100, 32'h00000103, 32'h0,        5'd6,  32'h0000100C, 0,  32'h80FFFF7F, 1'b1, 4'b1111, 32'h0,        0, 1'b0, 1'b1, 32'h00000080);
        run_op("sh",   1'b0, 2'b00, 1'b0, 1'b1, 3'b001, 32'h00000102, 32'h1234ABCD, 5'd0,  32'h00001010, 1,  32'h0,        1'b1, 4'b1100, 32'hABCDABCD, 1, 1'b0, 1'b0, 32'h0);
        run_op("lwmis",1'b1, 2'b01, 1'b1, 1'b0, 3'b010, 32'h00000102, 32'h0,        5'd7,  32'h00001014, 0,  32'h0,        1'b0, 4'b1111, 32'h0,        0, 1'b1, 1'b0, 32'h0);
        run_op("lh",   1'b1, 2'b01, 1'b1, 1'b0, 3'b001, 32'h00000102, 32'h0,        5'd8,  32'h00001018, 1,  32'h80FFFF7F, 1'b1, 4'b1111, 32'h0,        1, 1'b0, 1'b1, 32'hFFFF80FF);
        run_op("lhu",  1'b1, 2'b01, 1'b1, 1'b0, 3'b101, 32'h00000100, 32'h0,        5'd9,  32'h0000101C, 2,  32'h80FFFF7F, 1'b1, 4'b1111, 32'h0,        2, 1'b0, 1'b1, 32'h0000FF7F);
        run_op("sb",   1'b0, 2'b00, 1'b0, 1'b1, 3'b000, 32'h00000101, 32'h000000A5, 5'd0,  32'h00001020, 0,  32'h0,        1'b1, 4'b0010, 32'hA5A5A5A5, 0, 1'b0, 1'b0, 32'h0);
        run_op("sill", 1'b0, 2'b00, 1'b0, 1'b1, 3'b011, 32'h00000100, 32'h55555555, 5'd0,  32'h00001024, 0,  32'h0,        1'b0, 4'b1111, 32'h0,        0, 1'b1, 1'b0, 32'h0);
        run_op("add",  1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 32'h00000055, 32'h0,        5'd10, 32'h00001028, 0,  32'h0,        1'b0, 4'b1111, 32'h0,        0, 1'b0, 1'b1, 32'h0);
        run_op("jal",  1'b1, 2'b10, 1'b0, 1'b0, 3'b111, 32'h00002000, 32'h0,        5'd1,  32'h0000102C, 0,  32'h0,        1'b0, 4'b1111, 32'h0,        0, 1'b0, 1'b1, 32'h0);
        run_op("lw",   1'b1, 2'b01, 1'b1, 1'b0, 3'b010, 32'h00000104, 32'h0,        5'd11, 32'h00001030, 0,  32'h11223344, 1'b1, 4'b1111, 32'h0,        0, 1'b0, 1'b1, 32'h11223344);
        run_op("lwto", 1'b1, 2'b01, 1'b1, 1'b0, 3'b010, 32'h00000108, 32'h0,        5'd12, 32'h00001034, 1000, 32'h0,      1'b1, 4'b1111, 32'h0,        15, 1'b1, 1'b0, 32'h0);

        // Reset while a load is waiting on the bus
        @(negedge CLK);
        RegWriteM = 1'b1; ResultSrcM = 2'b01; MemReadM = 1'b1; MemWriteM = 1'b0;
        funct3M = 3'b010; ALUResultM = 32'h0000010C; RdM = 5'd13; PCPlus4M = 32'h00001038;
        DMemAck = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rstwait.pre_stall", {31'd0, StallM}, 32'd1);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("rstwait.req",   {31'd0, DMemReq}, 32'd0);
        chk("rstwait.stall", {31'd0, StallM}, 32'd0);
        chk("rstwait.rw",    {31'd0, RegWriteW}, 32'd0);
        chk("rstwait.exc",   {31'd0, ExcW}, 32'd0);
        chk("rstwait.pc4",   PCPlus4W, 32'd0);
        chk("rstwait.alu",   ALUResultW, 32'd0);
        chk("rstwait.rd",    {27'd0, RdW}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        run_op("lwpost", 1'b1, 2'b01, 1'b1, 1'b0, 3'b010, 32'h00000110, 32'h0, 5'd14, 32'h0000103C, 2, 32'hCAFEF00D, 1'b1, 4'b1111, 32'h0, 2, 1'b0, 1'b1, 32'hCAFEF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
